serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder: the additive counterpart to half_sub in the arithmetic set.

---
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start; done strobes for one cycle when Sum/Cout land.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, part;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s, co;
    logic             load, last;

    serial_adder_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // start is only honoured outside RUN, so mid-operation pulses are dropped
    assign load = (state != RUN) && start;
    assign last = (state == RUN) && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            part  <= '0;
            carry <= 1'b0;
            count <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            part  <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            part  <= {s, part[WIDTH-1:1]};
            carry <= co;
            count <= count + 1'b1;
            // outputs update only here, so they stay stable through RUN
            if (last) begin
                Sum  <= {s, part[WIDTH-1:1]};
                Cout <= co;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operations against an arithmetic A+B model.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] Sum;
    logic         Cout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_sum", 32'(Sum), 32'(prev_sum));
            chk("idle_cout", 32'(Cout), 32'(prev_cout));
        end
    endtask

    // One operation: accept edge, then W cycles, done on the W-th.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit disturb);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b};
        A = a;
        B = b;
        start = 1'b1;
        step();
        for (int k = 1; k <= W; k++) begin
            if (disturb) begin
                A = W'($urandom);
                B = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = hold;
            end
            step();
            if (k < W) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk("run_sum_stable", 32'(Sum), 32'(prev_sum));
                chk("run_cout_stable", 32'(Cout), 32'(prev_cout));
            end else begin
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_strobe", 32'(done), 32'd1);
                chk("done_sum", 32'(Sum), 32'(r[W-1:0]));
                chk("done_cout", 32'(Cout), 32'(r[W]));
            end
        end
        start = hold;
        prev_sum = r[W-1:0];
        prev_cout = r[W];
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        prev_sum = '0;
        prev_cout = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        rst = 1'b0;
        idle(2);

        // directed vectors
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        idle(2);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        idle(1);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        idle(1);
        // mid-RUN start pulses and operand changes are ignored
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        idle(W + 2);

        // start held high: back-to-back, busy low only in the DONE cycles
        run_op(8'h01, 8'h01, 1'b1, 1'b0);
        run_op(8'h01, 8'h01, 1'b1, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0);
        idle(1);

        // reset 4 cycles into RUN aborts without a done
        A = 8'hC3;
        B = 8'h7E;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(Sum), 32'd0);
        chk("abort_cout", 32'(Cout), 32'd0);
        prev_sum = '0;
        prev_cout = 1'b0;
        idle(W + 2);
        run_op(8'h81, 8'h80, 1'b0, 1'b0);

        // zero operands: previous result held until this done
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        idle(1);

        // random operations, random gaps, occasional back-to-back
        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
